// File: rtl/bip_debug_tx_if.sv
// -----------------------------------------------------------------------------
// bip_debug_tx_if
// Byte-stream valid/ready link between the debug exporter and its sink
// (normally a UART transmitter).
//   tx_data  : byte offered by the master
//   tx_valid : tx_data holds a byte to transfer
//   tx_ready : sink accepts a byte on this clock edge
// A byte moves on every rising edge where tx_valid && tx_ready.
// -----------------------------------------------------------------------------
interface bip_debug_tx_if #(
  parameter int NB_BYTE = 8
);
  logic [NB_BYTE-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/bip_debug_tx.sv
// -----------------------------------------------------------------------------
// bip_debug_tx
// Debug/export stage sitting after the BIP processor. It keeps the CPU enabled
// until a HALT opcode is fetched, then freezes the CPU, snapshots the cycle
// counter, PC and accumulator, and sends them as an 8-byte frame:
//   A5 | cnt_hi | cnt_lo | pc_hi | pc_lo | acc_hi | acc_lo | xor(bytes 1..6)
// The CPU stays frozen in DONE until i_restart.
//
// Ports
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous reset, active low
//   i_opcode   : opcode of the current instruction
//   i_counter  : executed-cycle counter
//   i_pc       : program counter
//   i_acc      : accumulator
//   i_restart  : leave DONE and resume the CPU
//   tx         : byte stream (master side): tx_data / tx_valid / tx_ready
//   o_cpu_en   : CPU clock-enable
//   o_busy     : frame being transmitted
//   o_done     : frame fully sent, CPU frozen
// All outputs come straight from flip-flops.
// -----------------------------------------------------------------------------
module bip_debug_tx #(
  parameter int                 NB_OPCODE    = 5,
  parameter int                 NB_ADDR      = 11,
  parameter int                 RAM_WIDTH    = 16,
  parameter int                 NB_BYTE      = 8,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 5'b00000,
  parameter logic [7:0]         FRAME_HEADER = 8'hA5
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NB_OPCODE-1:0] i_opcode,
  input  logic [NB_ADDR-1:0]   i_counter,
  input  logic [NB_ADDR-1:0]   i_pc,
  input  logic [RAM_WIDTH-1:0] i_acc,
  input  logic                 i_restart,
  bip_debug_tx_if.master       tx,
  output logic                 o_cpu_en,
  output logic                 o_busy,
  output logic                 o_done
);

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_RUN  = 2'd1,
    ST_SEND = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [2:0]           r_idx, w_idx_nxt;
  logic [NB_ADDR-1:0]   r_cnt, w_cnt_nxt;
  logic [NB_ADDR-1:0]   r_pc, w_pc_nxt;
  logic [RAM_WIDTH-1:0] r_acc, w_acc_nxt;

  logic [NB_BYTE-1:0]   r_tx_data, w_tx_data_nxt;
  logic                 r_tx_valid, w_tx_valid_nxt;
  logic                 r_cpu_en, w_cpu_en_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;

  logic                 w_xfer;

  // Frame byte selected by index, built from snapshot values only. Fields are
  // zero-extended to 16 bits so the high bytes carry the unused bits as 0.
  function automatic logic [7:0] frame_byte(
    input logic [2:0]           idx,
    input logic [NB_ADDR-1:0]   cnt,
    input logic [NB_ADDR-1:0]   pc,
    input logic [RAM_WIDTH-1:0] acc
  );
    logic [15:0] c16, p16, a16;
    logic [7:0]  b;
    c16 = 16'(cnt);
    p16 = 16'(pc);
    a16 = 16'(acc);
    case (idx)
      3'd0:    b = FRAME_HEADER;
      3'd1:    b = c16[15:8];
      3'd2:    b = c16[7:0];
      3'd3:    b = p16[15:8];
      3'd4:    b = p16[7:0];
      3'd5:    b = a16[15:8];
      3'd6:    b = a16[7:0];
      default: b = c16[15:8] ^ c16[7:0] ^ p16[15:8] ^ p16[7:0] ^ a16[15:8] ^ a16[7:0];
    endcase
    return b;
  endfunction

  // Handshake judged on the registered valid, so ready alone never advances.
  assign w_xfer = r_tx_valid && tx.tx_ready;

  // State and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= ST_ARM;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_pc       <= '0;
      r_acc      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_cpu_en   <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_pc       <= w_pc_nxt;
      r_acc      <= w_acc_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_cpu_en   <= w_cpu_en_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    case (r_state)
      // One cycle that swallows the all-zero opcode memory shows in reset.
      ST_ARM: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_opcode == HALT_OPCODE) begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = 3'd0;
          w_cnt_nxt   = i_counter;
          w_pc_nxt    = i_pc;
          w_acc_nxt   = i_acc;
        end
      end
      ST_SEND: begin
        if (w_xfer) begin
          w_idx_nxt = r_idx + 3'd1;
          if (r_idx == 3'd7) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_restart) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_ARM;
    endcase
  end

  // Output logic: decoded from the next state so the flops present the
  // values belonging to the state being entered on this edge.
  always_comb begin
    w_tx_valid_nxt = (w_state_nxt == ST_SEND);
    w_busy_nxt     = (w_state_nxt == ST_SEND);
    w_cpu_en_nxt   = (w_state_nxt == ST_RUN);
    w_done_nxt     = (w_state_nxt == ST_DONE);
    w_tx_data_nxt  = '0;
    if (w_state_nxt == ST_SEND)
      w_tx_data_nxt = NB_BYTE'(frame_byte(w_idx_nxt, w_cnt_nxt, w_pc_nxt, w_acc_nxt));
  end

  assign tx.tx_data  = r_tx_data;
  assign tx.tx_valid = r_tx_valid;
  assign o_cpu_en    = r_cpu_en;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: tb/tb_bip_debug_tx.sv
module tb_bip_debug_tx;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [4:0]  i_opcode = 5'd0;
  logic [10:0] i_counter = '0;
  logic [10:0] i_pc = '0;
  logic [15:0] i_acc = '0;
  logic        i_restart = 1'b0;
  logic        o_cpu_en, o_busy, o_done;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [63:0] FRAME1 = 64'hA501_2300_7FBE_EF0C;
  localparam logic [63:0] FRAME2 = 64'hA507_FF00_0000_00F8;

  bip_debug_tx_if #(.NB_BYTE(8)) tx_if ();

  bip_debug_tx dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_opcode  (i_opcode),
    .i_counter (i_counter),
    .i_pc      (i_pc),
    .i_acc     (i_acc),
    .i_restart (i_restart),
    .tx        (tx_if.master),
    .o_cpu_en  (o_cpu_en),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic cpu_en_exp);
    check({tag, "_valid"}, 32'(tx_if.tx_valid), 32'(1'b0));
    check({tag, "_busy"},  32'(o_busy),         32'(1'b0));
    check({tag, "_done"},  32'(o_done),         32'(1'b0));
    check({tag, "_cpuen"}, 32'(o_cpu_en),       32'(cpu_en_exp));
  endtask

  // Present HALT with the given snapshot for one edge (called at a negedge).
  task automatic halt_now(input logic [10:0] c, input logic [10:0] p, input logic [15:0] a);
    i_counter = c;
    i_pc      = p;
    i_acc     = a;
    i_opcode  = 5'd0;
    @(posedge i_clk);
    @(negedge i_clk);
    i_opcode  = 5'd3;
  endtask

  // Drain one frame from the first byte. bp selects the ready pattern
  // 1,0,0,1,0,0...; mangle clears live inputs after capture. A restart pulse
  // is issued during SEND and must be ignored.
  task automatic run_frame(input logic [63:0] frame, input bit bp, input bit mangle);
    int k = 0;
    int cyc = 0;
    logic rdy;
    while (k < 8 && cyc < 40) begin
      rdy = bp ? (cyc % 3 == 0) : 1'b1;
      check("send_valid", 32'(tx_if.tx_valid), 32'(1'b1));
      check("send_busy",  32'(o_busy),         32'(1'b1));
      check("send_cpuen", 32'(o_cpu_en),       32'(1'b0));
      check($sformatf("byte%0d", k), 32'(tx_if.tx_data), 32'(frame[63-8*k -: 8]));
      i_restart = (cyc == 1);
      if (mangle && cyc == 1) begin
        i_acc     = 16'h0000;
        i_counter = 11'h000;
        i_pc      = 11'h000;
      end
      tx_if.tx_ready = rdy;
      @(posedge i_clk);
      @(negedge i_clk);
      if (rdy) k++;
      cyc++;
    end
    i_restart = 1'b0;
    check("frame_complete", 32'(k), 32'd8);
    tx_if.tx_ready = 1'b1;
    check("done_done",  32'(o_done),         32'(1'b1));
    check("done_busy",  32'(o_busy),         32'(1'b0));
    check("done_valid", 32'(tx_if.tx_valid), 32'(1'b0));
    check("done_cpuen", 32'(o_cpu_en),       32'(1'b0));
    // Stays frozen while no restart arrives
    @(posedge i_clk);
    @(negedge i_clk);
    check("done_hold",  32'(o_done),         32'(1'b1));
    check("done_hold_valid", 32'(tx_if.tx_valid), 32'(1'b0));
  endtask

  task automatic restart_now();
    i_opcode  = 5'd3;
    i_restart = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_restart = 1'b0;
    check("restart_done",  32'(o_done),   32'(1'b0));
    check("restart_cpuen", 32'(o_cpu_en), 32'(1'b1));
    check("restart_valid", 32'(tx_if.tx_valid), 32'(1'b0));
  endtask

  initial begin
    tx_if.tx_ready = 1'b1;

    // Reset held with HALT-looking zero opcode on the bus
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_idle_outputs("rst", 1'b0);
    check("rst_data", 32'(tx_if.tx_data), 32'h0);

    // Release with opcode 0: ARM must mask it
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_idle_outputs("arm_to_run", 1'b1);
    i_opcode = 5'd3;
    repeat (3) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check_idle_outputs("run_noframe", 1'b1);

    // Basic dump, ready held high
    halt_now(11'h123, 11'h07F, 16'hBEEF);
    run_frame(FRAME1, 1'b0, 1'b0);
    restart_now();

    // Backpressure plus live inputs cleared after capture
    halt_now(11'h123, 11'h07F, 16'hBEEF);
    run_frame(FRAME1, 1'b1, 1'b1);
    restart_now();

    // Second dump with a different snapshot
    halt_now(11'h7FF, 11'h000, 16'h0000);
    run_frame(FRAME2, 1'b0, 1'b0);
    restart_now();

    // Reset in the middle of a frame
    halt_now(11'h123, 11'h07F, 16'hBEEF);
    tx_if.tx_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("mid_byte%0d", k), 32'(tx_if.tx_data), 32'(FRAME1[63-8*k -: 8]));
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check("mid_valid_before", 32'(tx_if.tx_valid), 32'(1'b1));
    #2 i_rst = 1'b0;
    #1;
    check_idle_outputs("mid_rst", 1'b0);
    check("mid_rst_data", 32'(tx_if.tx_data), 32'h0);
    @(negedge i_clk);
    i_opcode = 5'd0;
    i_rst = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check_idle_outputs("post_rst_arm", 1'b1);
    i_opcode = 5'd3;
    repeat (4) begin
      @(posedge i_clk);
      @(negedge i_clk);
    end
    check_idle_outputs("post_rst_run", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bip_debug_tx.md
# bip_debug_tx

Debug/export stage directly downstream of the BIP processor. While the CPU runs it keeps the CPU enabled. When the CPU fetches the HALT instruction, it:
- freezes the CPU,
- snapshots the cycle counter, PC and accumulator,
- serializes the snapshot as a fixed 8-byte frame over a valid/ready byte stream (normally a UART transmitter).

It then holds the CPU frozen until a restart request.

## Interface
Parameters:
- NB_OPCODE, 5, opcode width.
- NB_ADDR, 11, width of cycle counter and PC.
- RAM_WIDTH, 16, accumulator width.
- NB_BYTE, 8, width of the output stream.
- HALT_OPCODE, 5'b00000, opcode that triggers a dump.
- FRAME_HEADER, 8'hA5, first byte of every frame.

Ports:
- i_clk  in  1  single clock, all state on rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_opcode  in  NB_OPCODE  opcode of the current instruction.
- i_counter  in  NB_ADDR  executed-cycle counter.
- i_pc  in  NB_ADDR  current program counter.
- i_acc  in  RAM_WIDTH  accumulator value.
- i_restart  in  1  pulse; leaves DONE and resumes the CPU.
- i_tx_ready  in  1  sink can accept a byte this cycle.
- o_tx_data  out  NB_BYTE  byte being offered.
- o_tx_valid  out  1  o_tx_data is valid.
- o_cpu_en  out  1  CPU clock-enable.
- o_busy  out  1  frame transmission in progress.
- o_done  out  1  frame fully sent, CPU frozen.

## Operation
- States: ARM, RUN, SEND, DONE.
- Reset (async, i_rst=0) forces:
  - state=ARM, byte index=0, snapshot registers=0;
  - o_tx_valid=0, o_tx_data=0, o_cpu_en=0, o_busy=0, o_done=0.
- ARM:
  - lasts exactly one cycle after reset release, then goes to RUN;
  - masks the all-zero instruction that memory outputs during reset.
- RUN:
  - o_cpu_en=1.
  - If i_opcode==HALT_OPCODE is sampled, then on the same edge:
    - snapshot {i_counter, i_pc, i_acc};
    - set byte index=0;
    - go to SEND.
- Frame bytes, in order:
  - 0: FRAME_HEADER
  - 1: counter[10:8] zero-extended to 8 bits
  - 2: counter[7:0]
  - 3: pc[10:8] zero-extended to 8 bits
  - 4: pc[7:0]
  - 5: acc[15:8]
  - 6: acc[7:0]
  - 7: XOR of bytes 1..6
- The checksum is computed from the snapshot registers, not the live inputs.
- SEND:
  - o_tx_valid=1, o_busy=1, o_cpu_en=0, o_tx_data=byte[index].
  - A transfer occurs on an edge where o_tx_valid && i_tx_ready; index then increments.
  - A transfer at index 7 moves the state to DONE.
- Handshake rules:
  - once valid is raised, valid and data stay stable until the transfer;
  - valid never drops mid-frame;
  - i_tx_ready while valid=0 is ignored.
- DONE:
  - o_done=1, o_cpu_en=0, o_tx_valid=0.
  - i_restart=1 moves the state to RUN; o_cpu_en=1 from the next cycle.
  - i_restart in any other state is ignored.
- Live inputs (i_counter, i_pc, i_acc) changing after the capture do not affect the frame.
- A HALT opcode present in RUN right after a restart triggers a new dump.

## Timing
- All outputs are registered; no combinational path from any input to any output.
- Let edge N be the edge on which RUN samples HALT:
  - from N: o_cpu_en=0, o_tx_valid=1, o_busy=1, o_tx_data=FRAME_HEADER;
  - the HALT instruction itself is executed with o_cpu_en=1.
- With i_tx_ready held 1:
  - bytes transfer on edges N+1..N+8;
  - o_done=1 and o_busy=0 from edge N+8.
- Each cycle of i_tx_ready=0 adds exactly one cycle of latency.
- Back-to-back transfers at one byte per cycle are supported.
- Reset asserted mid-frame: o_tx_valid drops immediately (asynchronously); the frame is abandoned, not resumed.
- Restart at edge M: o_done=0 and o_cpu_en=1 from M.

## Test plan
- Reset then run: hold i_rst=0, check all outputs 0; release with i_opcode=0 → ARM masks it, o_cpu_en=1 one cycle later, no frame.
- Basic dump: counter=0x123, pc=0x07F, acc=0xBEEF, HALT sampled, i_tx_ready=1 → bytes A5,01,23,00,7F,BE,EF,0C on 8 consecutive edges, then o_done=1.
- Backpressure: same snapshot, i_tx_ready toggling 1,0,0,1,… → identical byte sequence, data and valid stable while ready=0, no byte duplicated or dropped.
- Snapshot isolation: change i_acc to 0x0000 during SEND → frame still carries BE,EF and checksum 0C.
- Restart: i_restart in SEND ignored; in DONE → o_cpu_en=1 next cycle. A second HALT with counter=0x7FF, pc=0, acc=0 → A5,07,FF,00,00,00,00,F8.
- Reset mid-frame: assert i_rst after the third byte transfers → o_tx_valid=0 immediately; after release the block goes ARM→RUN and no partial frame resumes.
